pc_fetch_ctrl: RTL and testbench

Sequencer for the 32-bit program counter register. It owns the PC value and handles the instruction-fetch handshake with instruction memory. It selects the next PC from sequential, branch, jump, exception-return and exception sources, and holds the PC under pipeline stall. It sits between the decode/execute control logic and the instruction memory port.

---
 rtl/pc_fetch_ctrl.sv | 136 +++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// Program counter sequencer with an instruction-fetch handshake and a one-entry redirect slot.
// Optional misaligned-target trap: define PC_ALIGN_CHECK_EN.
module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_VECTOR = 32'h0040_0000,
   parameter logic [31:0] EXC_VECTOR   = 32'h0040_0004
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        imem_ready,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic        exc_req,
   input  logic        eret,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        fetch_req,
   output logic [31:0] epc,
   output logic        redirect_pending
`ifdef PC_ALIGN_CHECK_EN
   ,
   output logic        misalign_err
`endif
);

   typedef enum logic [1:0] {IDLE, FETCH, STALL} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] epc_q, epc_d;
   logic        slot_v_q, slot_v_d;
   logic [31:0] slot_tgt_q, slot_tgt_d;
   logic        fetch_req_q, fetch_req_d;
   logic        redir_v, advance;
   logic [31:0] redir_tgt, npc;
`ifdef PC_ALIGN_CHECK_EN
   logic        slot_exc_q, slot_exc_d;
   logic        merr_q, merr_d;
   logic        npc_exc;
`endif

   assign pc_plus4 = pc_q + 32'd4;

   always_comb begin
      redir_v   = eret | jump | branch_taken;
      redir_tgt = eret ? epc_q : (jump ? jump_target : branch_target);
      npc       = exc_req  ? EXC_VECTOR :
                  slot_v_q ? slot_tgt_q :
                  redir_v  ? redir_tgt  : pc_plus4;
      advance   = ((state_q == FETCH) && imem_ready && !stall) ||
                  ((state_q == STALL) && !stall);
      state_d    = state_q;
      pc_d       = pc_q;
      epc_d      = epc_q;
      slot_v_d   = slot_v_q;
      slot_tgt_d = slot_tgt_q;
`ifdef PC_ALIGN_CHECK_EN
      slot_exc_d = slot_exc_q;
      merr_d     = 1'b0;
      npc_exc    = exc_req | (slot_v_q & slot_exc_q);
`endif
      case (state_q)
         IDLE: state_d = FETCH;
         FETCH, STALL: begin
            // Exceptions always take the slot; other redirects only fill an empty one.
            if (exc_req) begin
               epc_d      = pc_q;
               slot_v_d   = 1'b1;
               slot_tgt_d = EXC_VECTOR;
`ifdef PC_ALIGN_CHECK_EN
               slot_exc_d = 1'b1;
`endif
            end else if (redir_v && !slot_v_q) begin
               slot_v_d   = 1'b1;
               slot_tgt_d = redir_tgt;
`ifdef PC_ALIGN_CHECK_EN
               slot_exc_d = 1'b0;
`endif
            end
            if (advance) begin
               pc_d     = npc;
               slot_v_d = 1'b0;
               state_d  = FETCH;
`ifdef PC_ALIGN_CHECK_EN
               if (!npc_exc && (npc[1:0] != 2'b00)) begin
                  pc_d   = EXC_VECTOR;
                  epc_d  = pc_q;
                  merr_d = 1'b1;
               end
`endif
            end else if ((state_q == FETCH) && imem_ready) begin
               state_d = STALL;
            end
         end
         default: state_d = IDLE;
      endcase
      fetch_req_d = (state_d == FETCH);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         pc_q        <= RESET_VECTOR;
         epc_q       <= 32'd0;
         slot_v_q    <= 1'b0;
         slot_tgt_q  <= 32'd0;
         fetch_req_q <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
         slot_exc_q  <= 1'b0;
         merr_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         epc_q       <= epc_d;
         slot_v_q    <= slot_v_d;
         slot_tgt_q  <= slot_tgt_d;
         fetch_req_q <= fetch_req_d;
`ifdef PC_ALIGN_CHECK_EN
         slot_exc_q  <= slot_exc_d;
         merr_q      <= merr_d;
`endif
      end
   end

   assign pc               = pc_q;
   assign epc              = epc_q;
   assign fetch_req        = fetch_req_q;
   assign redirect_pending = slot_v_q;
`ifdef PC_ALIGN_CHECK_EN
   assign misalign_err     = merr_q;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: directed scenarios followed by random traffic,
// each cycle's expected outputs produced by a behavioural model and queued for a monitor.
module tb_pc_fetch_ctrl;
   localparam logic [31:0] RV = 32'h0040_0000;
   localparam logic [31:0] EV = 32'h0040_0004;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_ready = 1'b0, stall = 1'b0, branch_taken = 1'b0, jump = 1'b0;
   logic        exc_req = 1'b0, eret = 1'b0;
   logic [31:0] branch_target = '0, jump_target = '0;
   logic [31:0] pc, pc_plus4, epc;
   logic        fetch_req, redirect_pending;
   logic        misalign_err;

   always #5 clk = ~clk;

   pc_fetch_ctrl dut (
      .clk(clk), .rst(rst), .imem_ready(imem_ready), .stall(stall),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .jump(jump), .jump_target(jump_target), .exc_req(exc_req), .eret(eret),
      .pc(pc), .pc_plus4(pc_plus4), .fetch_req(fetch_req), .epc(epc),
      .redirect_pending(redirect_pending)
`ifdef PC_ALIGN_CHECK_EN
      , .misalign_err(misalign_err)
`endif
   );
`ifndef PC_ALIGN_CHECK_EN
   assign misalign_err = 1'b0;
`endif

   typedef struct {
      logic [31:0] pc, epc;
      logic fr, rp, merr;
   } exp_t;
   exp_t sb_q[$];

   int total = 0, bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the fetcher is "busy" (sequencing), "waiting" (stalled), or "starting".
   int          m_mode;  // 0 starting, 1 fetching, 2 stalled
   logic [31:0] m_pc, m_epc, m_tgt;
   logic        m_have, m_have_exc, m_merr;

   task automatic model(input logic r, rdy, stl, br, input logic [31:0] bt,
                        input logic jp, input logic [31:0] jt, input logic ex, er);
      logic [31:0] next_pc, req_tgt, old_pc;
      logic        moves, req, from_exc;
      exp_t e;
      if (r) begin
         m_mode = 0; m_pc = RV; m_epc = 0; m_have = 0; m_have_exc = 0; m_merr = 0;
      end else if (m_mode == 0) begin
         m_mode = 1; m_merr = 0;
      end else begin
         old_pc  = m_pc;
         moves   = (m_mode == 1) ? (rdy && !stl) : !stl;
         req     = er || jp || br;
         req_tgt = er ? m_epc : jp ? jt : bt;
         if (ex)          begin next_pc = EV;       from_exc = 1;          end
         else if (m_have) begin next_pc = m_tgt;    from_exc = m_have_exc; end
         else if (req)    begin next_pc = req_tgt;  from_exc = 0;          end
         else             begin next_pc = old_pc + 4; from_exc = 0;        end
         if (ex) m_epc = old_pc;
         m_merr = 0;
         if (moves) begin
            m_pc = next_pc;
`ifdef PC_ALIGN_CHECK_EN
            if (!from_exc && next_pc[1:0] != 0) begin
               m_pc = EV; m_epc = old_pc; m_merr = 1;
            end
`endif
            m_have = 0;
            m_mode = 1;
         end else begin
            if (ex) begin m_have = 1; m_tgt = EV; m_have_exc = 1; end
            else if (req && !m_have) begin m_have = 1; m_tgt = req_tgt; m_have_exc = 0; end
            if (m_mode == 1 && rdy) m_mode = 2;
         end
      end
      e.pc = m_pc; e.epc = m_epc; e.fr = (m_mode == 1); e.rp = m_have; e.merr = m_merr;
      sb_q.push_back(e);
   endtask

   task automatic step(input logic r, rdy, stl, br, input logic [31:0] bt,
                       input logic jp, input logic [31:0] jt, input logic ex, er);
      @(negedge clk);
      rst = r; imem_ready = rdy; stall = stl; branch_taken = br; branch_target = bt;
      jump = jp; jump_target = jt; exc_req = ex; eret = er;
      model(r, rdy, stl, br, bt, jp, jt, ex, er);
   endtask

   task automatic after_edge;
      @(posedge clk); #2;
   endtask

   task automatic run(input logic rdy, stl);
      step(0, rdy, stl, 0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: the DUT presents a registered state every cycle; compare against the queue.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk); #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("pc", pc, e.pc);
            chk("pc_plus4", pc_plus4, e.pc + 32'd4);
            chk("epc", epc, e.epc);
            chk("fetch_req", {31'd0, fetch_req}, {31'd0, e.fr});
            chk("redirect_pending", {31'd0, redirect_pending}, {31'd0, e.rp});
            chk("misalign_err", {31'd0, misalign_err}, {31'd0, e.merr});
         end
      end
   end

   initial begin
      logic [31:0] held, t1, t2;
      // Sequential advance from reset
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      after_edge; chk("reset_pc", pc, RV); chk("reset_fr", {31'd0, fetch_req}, 0);
      chk("reset_epc", epc, 0);
      run(1, 0); after_edge; chk("first_fetch_pc", pc, RV); chk("first_fr", {31'd0, fetch_req}, 1);
      run(1, 0); after_edge; chk("seq_pc4", pc, 32'h0040_0004);
      run(1, 0); after_edge; chk("seq_pc8", pc, 32'h0040_0008);
      // Older pending branch beats newer jump
      step(0, 0, 0, 1, 32'h0040_0100, 0, 0, 0, 0);
      after_edge; chk("pend_set", {31'd0, redirect_pending}, 1);
      step(0, 0, 0, 0, 0, 1, 32'h0040_0200, 0, 0);
      run(0, 0);
      run(1, 0); after_edge; chk("branch_wins", pc, 32'h0040_0100);
      chk("pend_clr", {31'd0, redirect_pending}, 0);
      // Exception over pending branch, then eret
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      run(1, 0);
      repeat (4) run(1, 0);
      after_edge; chk("pc_10", pc, 32'h0040_0010);
      step(0, 0, 0, 1, 32'h0050_0000, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0, 1, 0);
      after_edge; chk("exc_pc", pc, EV); chk("exc_epc", epc, 32'h0040_0010);
      step(0, 1, 0, 0, 0, 0, 0, 0, 1);
      after_edge; chk("eret_pc", pc, 32'h0040_0010);
      // Stall hold
      held = 32'h0040_0010;
      repeat (4) run(1, 1);
      after_edge; chk("stall_pc", pc, held); chk("stall_fr", {31'd0, fetch_req}, 0);
      run(1, 0); after_edge; chk("unstall_pc", pc, held + 4); chk("unstall_fr", {31'd0, fetch_req}, 1);
      // Reset while stalled with a pending jump
      step(0, 1, 1, 0, 0, 1, 32'h0040_0300, 0, 0);
      after_edge; chk("stall_pend", {31'd0, redirect_pending}, 1);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      after_edge; chk("rst_pc", pc, RV); chk("rst_rp", {31'd0, redirect_pending}, 0);
      chk("rst_epc", epc, 0); chk("rst_fr", {31'd0, fetch_req}, 0);
      // Wrap-around
      run(1, 0);
      step(0, 1, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
      after_edge; chk("wrap_pre", pc, 32'hFFFF_FFFC);
      run(1, 0); after_edge; chk("wrap_pc", pc, 32'h0000_0000);
      // Misaligned jump
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      run(1, 0);
      step(0, 1, 0, 0, 0, 1, 32'h0040_0102, 0, 0);
      after_edge;
`ifdef PC_ALIGN_CHECK_EN
      chk("mis_pc", pc, EV); chk("mis_epc", epc, RV); chk("mis_err", {31'd0, misalign_err}, 1);
      run(1, 0); after_edge; chk("mis_err_drop", {31'd0, misalign_err}, 0);
`else
      chk("unaligned_pc", pc, 32'h0040_0102);
`endif
      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         t1 = $urandom; t2 = $urandom;
         if ($urandom_range(0, 7) != 0) begin t1[1:0] = 2'b00; t2[1:0] = 2'b00; end
         step(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 7), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 9) == 0), t1, ($urandom_range(0, 9) == 0), t2,
              ($urandom_range(0, 19) == 0), ($urandom_range(0, 11) == 0));
      end
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #3;
      if (sb_q.size() != 0) chk("sb_drained", sb_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
